pop_reader: RTL
===============

POP_READER -- requirements
Module: pop_reader

Interface
REQ-001 Parameter POPSIZE, default 100, SHALL be the number of entries per population frame scanned.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL be the sample width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL be updated on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 new_data  input  1  SHALL be the one-cycle pulse from the population buffer indicating that a fresh frame is readable.
REQ-006 data_vld  input  1  SHALL be the buffer read-response strobe.
REQ-007 data_out  input  DATA_WIDTH  SHALL be the buffer read data, qualified by data_vld.
REQ-008 read_addr  output  $clog2(POPSIZE)  SHALL be the buffer read index.
REQ-009 rd_rqst  output  1  SHALL be the buffer read request.
REQ-010 out_data  output  DATA_WIDTH  SHALL be the streamed sample.
REQ-011 out_index  output  $clog2(POPSIZE)  SHALL be the index of out_data.
REQ-012 out_valid / out_ready  output / input  1 each  SHALL form the stream handshake; transfer occurs when both are 1.
REQ-013 out_first / out_last  output  1 each  SHALL mark index 0 and index POPSIZE-1, qualified by out_valid.
REQ-014 frame_done  output  1  SHALL pulse for one cycle after the out_last transfer.
REQ-015 overrun  output  1  SHALL be a sticky flag, cleared only by reset.

Function
REQ-016 The FSM SHALL have states IDLE, REQ and WAIT.
REQ-017 IDLE: on new_data or pending=1, the block SHALL clear addr to 0, clear pending and go to REQ.
REQ-018 REQ: when slot_free = (!out_valid || out_ready), the block SHALL drive rd_rqst=1 for exactly that cycle with read_addr=addr, then go to WAIT; otherwise it SHALL hold rd_rqst=0 and remain in REQ.
REQ-019 In every state other than REQ with slot_free, rd_rqst SHALL be 0; read_addr SHALL always equal addr.
REQ-020 WAIT: if data_vld=1, the block SHALL load out_data=data_out, out_index=addr and out_valid=1, set out_first=(addr==0) and out_last=(addr==POPSIZE-1), then either go to IDLE (addr==POPSIZE-1) or increment addr and go to REQ.
REQ-021 WAIT: if data_vld=0, the request was not granted; the block SHALL return to REQ with addr unchanged, so requests are re-issued until granted.
REQ-022 The response latency SHALL be exactly one cycle after rd_rqst; data_vld outside WAIT SHALL be ignored.
REQ-023 out_valid SHALL clear on transfer unless reloaded in the same cycle; out_data and out_index SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 Per frame, indices 0..POPSIZE-1 SHALL appear in order with no gaps or duplicates.
REQ-025 new_data outside IDLE SHALL set pending; new_data while pending=1 SHALL set overrun=1, and the extra frame SHALL be dropped.
REQ-026 new_data in IDLE in the same cycle as the final WAIT capture SHALL set pending, and the next scan SHALL start in the following cycle.
REQ-027 Address arithmetic SHALL be unsigned, with addr never exceeding POPSIZE-1.

Reset
REQ-028 While rst=0, the block SHALL enter IDLE with addr=0, pending=0, rd_rqst=0, read_addr=0, out_valid=0, out_data=0, out_index=0, out_first=0, out_last=0, frame_done=0 and overrun=0.
REQ-029 Reset asserted mid-scan SHALL abandon the frame; no partial-frame frame_done SHALL be produced.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the default POPSIZE, FRAME_SIZE and DATA_WIDTH constants used by both the population buffer and pop_reader.
REQ-031 The output register and stream handshake SHALL be a sub-module named stream_out_reg; the FSM SHALL stay in pop_reader.

Verification
REQ-032 Reset, one new_data pulse, data_vld returned one cycle after every rd_rqst, out_ready=1 -> 100 transfers with indices 0..99, out_first at index 0, out_last at index 99, frame_done one cycle after index 99.
REQ-033 Responder withholds data_vld on every other request -> each address is re-requested and the stream is still 0..99 with no duplicates.
REQ-034 out_ready=0 for 10 cycles at index 5 -> out_data/out_index held at 5, no rd_rqst during the stall, resumes at index 6.
REQ-035 Two new_data pulses during a scan -> pending set then overrun=1; exactly one further frame is streamed after the first frame's frame_done.
REQ-036 rst=0 asserted at index 50 -> all outputs 0 immediately; a following new_data starts at index 0.

Source files
------------

// File: rtl/pop_reader_pkg.sv
// Shared constants and FSM state type for the population buffer and pop_reader.
package pop_reader_pkg;

    localparam int DEF_POPSIZE    = 100;
    localparam int DEF_FRAME_SIZE = DEF_POPSIZE;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } pop_state_t;

    // Index width, never below one bit so degenerate sizes still elaborate.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pop_reader_stream_out_reg.sv
// Output holding register and valid/ready handshake for the pop_reader sample stream.
module stream_out_reg
    import pop_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IDX_WIDTH  = idx_width(DEF_POPSIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [IDX_WIDTH-1:0]  load_index,
    input  logic                  load_first,
    input  logic                  load_last,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_WIDTH-1:0]  out_index,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  slot_free
);

    logic xfer;

    assign xfer      = out_valid && out_ready;
    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_index  <= '0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= xfer && out_last;
            // A load only ever arrives when the slot is empty or draining this cycle.
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_index <= load_index;
                out_first <= load_first;
                out_last  <= load_last;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pop_reader.sv
// Scans a population buffer frame by frame and streams its entries with valid/ready.
//   state | meaning
//   IDLE  | waiting for a fresh frame (new_data or pending)
//   REQ   | issue a read for addr once the output slot is free
//   WAIT  | capture the one-cycle read response, or re-request if none came
module pop_reader
    import pop_reader_pkg::*;
#(
    parameter int POPSIZE    = DEF_POPSIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int AW        = idx_width(POPSIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  new_data,
    input  logic                  data_vld,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic [AW-1:0]         read_addr,
    output logic                  rd_rqst,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [AW-1:0]         out_index,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(POPSIZE - 1);

    pop_state_t    state, state_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic          pending, pending_nxt;
    logic          overrun_set;
    logic          load;
    logic          slot_free;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            addr    <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr    <= addr_nxt;
            pending <= pending_nxt;
            if (overrun_set) begin
                overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr;
        pending_nxt = pending;
        rd_rqst     = 1'b0;
        load        = 1'b0;

        // A second frame arriving while one is already queued is dropped.
        overrun_set = new_data && pending;
        if (new_data && !pending) begin
            pending_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (new_data || pending) begin
                    addr_nxt    = '0;
                    pending_nxt = 1'b0;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                if (slot_free) begin
                    rd_rqst   = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (data_vld) begin
                    load = 1'b1;
                    if (addr == LAST_ADDR) begin
                        state_nxt = IDLE;
                    end else begin
                        addr_nxt  = addr + AW'(1);
                        state_nxt = REQ;
                    end
                end else begin
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign read_addr = addr;

    stream_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (AW)
    ) u_stream_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (data_out),
        .load_index (addr),
        .load_first (addr == '0),
        .load_last  (addr == LAST_ADDR),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_first  (out_first),
        .out_last   (out_last),
        .frame_done (frame_done),
        .slot_free  (slot_free)
    );

endmodule
